// File: rtl/axis_pkt_source_pkg.sv
// Shared definitions for the byte-stream packet source and the stream FIFO
// it feeds: default widths and the transmitter state encoding.
package axis_pkt_source_pkg;

  // Default stream geometry shared with the 2048-deep stream FIFO.
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 12;
  localparam int DEF_MAX_LEN = 2048;

  // Transmitter states: waiting for a command, streaming beats, enforced idle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage : axis_pkt_source_pkg

// File: rtl/axis_pkt_source_if.sv
// Byte-wide AXI-Stream-style link: the source drives data/valid/last and the
// sink (normally the stream FIFO write side) returns ready.
interface axis_pkt_source_if
  import axis_pkt_source_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface : axis_pkt_source_if

// File: rtl/axis_pkt_source_pkt_gap_timer.sv
// Loadable down-counter that times the idle gap between packets. It is loaded
// with (gap length - 1) on the last handshake and reports expired once the
// count has reached zero, i.e. on the final gap cycle.
module pkt_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Load takes priority; otherwise count down on each tick and rest at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule : pkt_gap_timer

// File: rtl/axis_pkt_source.sv
// Packet transmitter: on a start command in IDLE it streams one packet of
// min(pkt_len, MAX_LEN) beats carrying seed, seed+1, ... (mod 2^DATA_W),
// flags the final beat with tlast, honours ready backpressure, then holds a
// fixed idle gap before accepting the next command.
module axis_pkt_source
  import axis_pkt_source_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pkt_count,
  axis_pkt_source_if.master     m_axis
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;       // beats still to send, including the one on the bus
  logic [LEN_W-1:0] req_len;     // requested length clamped to MAX_LEN
  logic             beat_xfer;
  logic             last_xfer;
  logic             gap_load;
  logic             gap_tick;
  logic             gap_expired;

  assign req_len   = (pkt_len > MAX_LEN_V) ? MAX_LEN_V : pkt_len;
  assign beat_xfer = m_axis.tvalid && m_axis.tready;
  assign last_xfer = beat_xfer && m_axis.tlast;
  assign gap_load  = (state_q == SEND) && last_xfer && (GAP_CYCLES != 0);
  assign gap_tick  = (state_q == GAP);

  pkt_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .tick     (gap_tick),
    .expired  (gap_expired)
  );

  // Packet FSM with registered stream and status outputs.
  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see the pre-edge values; blocking assignments would create order races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          // Zero-length requests are dropped without any visible effect.
          if (start && (pkt_len != '0)) begin
            rem_q         <= req_len;
            m_axis.tdata  <= seed;
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= (req_len == LEN_W'(1));
            busy          <= 1'b1;
            state_q       <= SEND;
          end
        end

        SEND: begin
          // Outputs only move on a handshake, so a stalled beat stays put.
          if (beat_xfer) begin
            if (m_axis.tlast) begin
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              rem_q         <= '0;
              done          <= 1'b1;
              pkt_count     <= pkt_count + CNT_W'(1);
              if (GAP_CYCLES == 0) begin
                busy    <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= GAP;
              end
            end else begin
              m_axis.tdata <= m_axis.tdata + DATA_W'(1);
              rem_q        <= rem_q - LEN_W'(1);
              m_axis.tlast <= (rem_q == LEN_W'(2));
            end
          end
        end

        GAP: begin
          if (gap_expired) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : axis_pkt_source

// File: tb/tb_axis_pkt_source.sv
// Self-checking bench for axis_pkt_source. Expected streams come from the
// packet rules (len clamped to MAX, byte k = seed + k mod 256, last on the
// final beat); a negedge monitor captures handshakes, stall stability and
// inter-packet idle gaps.
module tb_axis_pkt_source;

  localparam int GAP = 2;
  localparam int MAX = 2048;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] pkt_len;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  axis_pkt_source_if #(.DATA_W(8)) axis ();

  axis_pkt_source #(
    .DATA_W     (8),
    .LEN_W      (12),
    .MAX_LEN    (MAX),
    .GAP_CYCLES (GAP),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pkt_len   (pkt_len),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pkt_count (pkt_count),
    .m_axis    (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench bookkeeping.
  int    n_assert   = 0;
  int    n_fail     = 0;
  int    exp_count  = 0;
  int    exp_done   = 0;
  int    rx_rd      = 0;
  int    gap_rd     = 0;
  int    sink_occ   = 0;
  int    ready_mode = 0;   // 0: ready high, 1: fixed pattern, 2: random, 3: FIFO sink
  int    pat_idx    = 0;
  bit    pat [6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Monitor state.
  beat_t rx_q [$];
  int    gap_q [$];
  int    done_cnt     = 0;
  int    stall_err    = 0;
  int    withdraw_err = 0;
  int    gap_run      = 0;
  bit    in_gap       = 0;
  bit    have_prev    = 0;
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  // Negedge monitor: record beats, check stalled beats hold and valid is never
  // withdrawn mid-packet, and measure idle cycles between packets.
  always @(negedge clk) begin
    if (!reset_n) begin
      have_prev = 0;
      in_gap    = 0;
    end else begin
      if (have_prev) begin
        if (prev_v && !prev_r) begin
          if (!(axis.tvalid === 1'b1 && axis.tdata === prev_d && axis.tlast === prev_l))
            stall_err++;
        end else if (prev_v && prev_r && !prev_l) begin
          if (axis.tvalid !== 1'b1) withdraw_err++;
        end
      end
      if (in_gap) begin
        if (axis.tvalid) begin
          gap_q.push_back(gap_run);
          in_gap = 0;
        end else begin
          gap_run++;
        end
      end
      if (axis.tvalid && axis.tready) begin
        rx_q.push_back('{axis.tdata, axis.tlast});
        if (axis.tlast) begin
          in_gap  = 1;
          gap_run = 0;
        end
      end
      if (done) done_cnt++;
      prev_v    = axis.tvalid;
      prev_r    = axis.tready;
      prev_d    = axis.tdata;
      prev_l    = axis.tlast;
      have_prev = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    logic hs;
    hs = axis.tvalid && axis.tready;
    @(posedge clk);
    #1;
    if (hs) sink_occ++;
    case (ready_mode)
      0: axis.tready = 1'b1;
      1: begin
        axis.tready = pat[pat_idx];
        pat_idx     = (pat_idx + 1) % 6;
      end
      2: axis.tready = 1'($urandom_range(1, 0));
      3: axis.tready = (sink_occ < MAX);
      default: axis.tready = 1'b1;
    endcase
  endtask

  task automatic send_start(input int len, input logic [7:0] sd);
    start   = 1'b1;
    pkt_len = 12'(len);
    seed    = sd;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || axis.tvalid) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_count = 0;
    rx_rd     = rx_q.size();
  endtask

  // Compare captured beats against the packet rules for one packet.
  task automatic check_packet(input string tag, input int len, input logic [7:0] sd);
    int         n, avail, bad;
    logic [7:0] e;
    n     = (len > MAX) ? MAX : len;
    avail = rx_q.size() - rx_rd;
    check({tag, "_beats"}, 32'(avail), 32'(n));
    bad = 0;
    for (int k = 0; k < avail && k < n; k++) begin
      e = sd + 8'(k);
      if (rx_q[rx_rd + k].d !== e || rx_q[rx_rd + k].l !== (k == n - 1)) bad++;
    end
    check({tag, "_data"}, 32'(bad), 32'd0);
    if (avail > 0)
      check({tag, "_final"}, {23'd0, rx_q[rx_rd + avail - 1].l, rx_q[rx_rd + avail - 1].d},
            {23'd0, 1'b1, 8'(sd + 8'(n - 1))});
    rx_rd += avail;
    exp_count++;
    exp_done++;
    check({tag, "_count"}, 32'(pkt_count), 32'(16'(exp_count)));
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    int         bad_gap;
    int         rlen;
    logic [7:0] rseed;
    int         n;

    reset_n     = 1'b0;
    start       = 1'b0;
    pkt_len     = '0;
    seed        = '0;
    axis.tready = 1'b0;
    #3;
    // Reset values are visible without any clock edge.
    check("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst_tlast", 32'(axis.tlast), 32'd0);
    check("rst_tdata", 32'(axis.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);
    tick();
    reset_n     = 1'b1;
    ready_mode  = 0;
    axis.tready = 1'b1;
    tick();

    // 1: len 4, seed 0x10, ready high.
    send_start(4, 8'h10);
    check("t1_latency_valid", 32'(axis.tvalid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_tdata%0d", k), 32'(axis.tdata), 32'(8'h10 + k));
      check($sformatf("t1_tlast%0d", k), 32'(axis.tlast), 32'(k == 3));
      tick();
    end
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_valid_drop", 32'(axis.tvalid), 32'd0);
    for (int g = 1; g < GAP; g++) begin
      tick();
      check("t1_gap_busy", 32'(busy), 32'd1);
    end
    tick();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check_packet("t1", 4, 8'h10);

    // 2: len 6, seed 0xFE, ready pattern 1,0,0,1,0,1,...
    ready_mode  = 1;
    pat_idx     = 1;
    axis.tready = pat[0];
    send_start(6, 8'hFE);
    wait_idle("t2", 100);
    check_packet("t2", 6, 8'hFE);
    check("t2_stall_stable", 32'(stall_err), 32'd0);
    check("t2_no_withdraw", 32'(withdraw_err), 32'd0);

    // 3: oversize request into a 2048-deep sink.
    ready_mode  = 3;
    sink_occ    = 0;
    axis.tready = 1'b1;
    send_start(2049, 8'h00);
    wait_idle("t3", 3000);
    check_packet("t3", 2049, 8'h00);
    check("t3_sink_full", 32'(sink_occ), 32'(MAX));
    check("t3_ready_low", 32'(axis.tready), 32'd0);
    // A full sink stalls the next packet on its first beat.
    n = rx_q.size();
    send_start(3, 8'h80);
    for (int k = 0; k < 5; k++) tick();
    check("t3_stall_no_xfer", 32'(rx_q.size() - n), 32'd0);
    check("t3_stall_valid", 32'(axis.tvalid), 32'd1);
    check("t3_stall_data", 32'(axis.tdata), 32'h80);
    sink_occ = 0;
    wait_idle("t3b", 100);
    check_packet("t3b", 3, 8'h80);

    // 4: boundary starts.
    ready_mode  = 0;
    axis.tready = 1'b1;
    send_start(0, 8'h55);
    for (int k = 0; k < 3; k++) begin
      check("t4_len0_valid", 32'(axis.tvalid), 32'd0);
      check("t4_len0_busy", 32'(busy), 32'd0);
      tick();
    end
    check("t4_len0_count", 32'(pkt_count), 32'(16'(exp_count)));
    check("t4_len0_done", 32'(done_cnt), 32'(exp_done));

    send_start(1, 8'hA7);
    check("t4_len1_tlast", 32'(axis.tlast), 32'd1);
    wait_idle("t4_len1", 20);
    check_packet("t4_len1", 1, 8'hA7);

    send_start(5, 8'h20);
    tick();
    send_start(3, 8'h99);                 // during SEND
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("t4_done_seen", 32'(n < 20), 32'd1);
    send_start(3, 8'h99);                 // during GAP
    wait_idle("t4_busy_start", 20);
    for (int k = 0; k < 3; k++) tick();
    check("t4_no_queued", 32'(axis.tvalid), 32'd0);
    check_packet("t4_busy_start", 5, 8'h20);

    // 5: reset on beat 3 of an 8-beat packet.
    send_start(8, 8'h30);
    for (int k = 0; k < 3; k++) tick();
    check("t5_on_beat3", 32'(axis.tdata), 32'h33);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_tvalid", 32'(axis.tvalid), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_count", 32'(pkt_count), 32'd0);
    tick();
    reset_n   = 1'b1;
    exp_count = 0;
    tick();
    rx_rd = rx_q.size();
    check("t5_no_resume", 32'(axis.tvalid), 32'd0);
    send_start(2, 8'h40);
    wait_idle("t5", 20);
    check_packet("t5", 2, 8'h40);

    // 6: ten back-to-back 3-beat packets, start as soon as busy falls.
    do_reset();
    gap_rd = gap_q.size();
    for (int i = 0; i < 10; i++) begin
      send_start(3, 8'(i * 16));
      wait_idle($sformatf("t6_%0d", i), 20);
      check_packet($sformatf("t6_%0d", i), 3, 8'(i * 16));
    end
    check("t6_count10", 32'(pkt_count), 32'd10);
    check("t6_gap_num", 32'(gap_q.size() - gap_rd), 32'd9);
    bad_gap = 0;
    for (int i = gap_rd; i < gap_q.size(); i++)
      if (gap_q[i] != GAP + 1) bad_gap++;
    check("t6_gap_len", 32'(bad_gap), 32'd0);

    // 7: random lengths, seeds and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      rlen  = int'($urandom_range(40, 1));
      rseed = 8'($urandom);
      send_start(rlen, rseed);
      wait_idle($sformatf("t7_%0d", i), 500);
      check_packet($sformatf("t7_%0d", i), rlen, rseed);
    end

    check("final_stall_stable", 32'(stall_err), 32'd0);
    check("final_no_withdraw", 32'(withdraw_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_axis_pkt_source
